mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters SHALL be: MEM_LAT, default 2, memory read/ack latency in cycles (legal 1..7); STARVE_MAX, default 4, consecutive data grants allowed while a fetch waits (legal 1..15).
REQ-002 Ports SHALL be, in order:
- Clk  in  1  clock, rising edge.
- Rst  in  1  asynchronous, active-low reset.
- if_req  in  1  instruction-fetch request, level.
- if_addr  in  32  fetch address.
- if_done  out  1  fetch complete, one-cycle pulse.
- if_rdata  out  32  fetched instruction.
- dm_req  in  1  data-access request, level.
- dm_we  in  1  1 = store, 0 = load.
- dm_addr  in  32  data address.
- dm_wdata  in  32  store data.
- dm_done  out  1  data access complete, one-cycle pulse.
- dm_rdata  out  32  load data.
- mem_en  out  1  memory command strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data.
- stall_if  out  1  fetch stage must hold.
- stall_dm  out  1  memory stage must hold.

Function
REQ-003 The block SHALL share one single-ported unified memory between fetch (IF) and data (DM) requesters, one transaction outstanding at a time.
REQ-004 FSM states SHALL be IDLE, WAIT_IF and WAIT_DM.
REQ-005 Issue cycle T: mem_en=1 for exactly one cycle; mem_addr, mem_we and mem_wdata come from the granted requester; state moves to WAIT_IF or WAIT_DM; latency counter loads MEM_LAT.
REQ-006 mem_we and mem_wdata SHALL be 0 for IF grants; mem_addr, mem_we and mem_wdata SHALL hold their last values when mem_en=0.
REQ-007 Memory returns mem_rdata valid at cycle T+MEM_LAT; loads, stores and fetches all complete on this timing.
REQ-008 At T+MEM_LAT the block SHALL capture mem_rdata into if_rdata (IF) or dm_rdata (DM loads only).
- The matching done output SHALL pulse at T+MEM_LAT+1.
- if_rdata and dm_rdata hold until the next capture.
- dm_rdata is unchanged by stores.
REQ-009 Requesters SHALL hold req, addr, we and wdata stable until their done pulse; behaviour for violations is undefined.
REQ-010 Arbitration SHALL occur in IDLE and in the done cycle.
- DM has priority over IF.
- Exception: when dm_streak equals STARVE_MAX and if_req=1, IF SHALL win.
REQ-011 In its done cycle, the just-completed requester SHALL NOT be re-granted; only the other requester may issue in that cycle. If it is not requesting, the block goes to IDLE.
REQ-012 dm_streak (4 bits) SHALL:
- increment on a DM grant while if_req=1;
- clear on any IF grant;
- clear on a DM grant while if_req=0;
- saturate at STARVE_MAX.
REQ-013 Combinational stall outputs: stall_if = if_req & ~if_done; stall_dm = dm_req & ~dm_done.
REQ-014 Simultaneous if_req and dm_req rising in IDLE SHALL grant DM, unless REQ-010 forces IF.
REQ-015 Sustained single-requester throughput SHALL be one transaction per MEM_LAT+2 cycles. Alternating requesters SHALL achieve one per MEM_LAT+1 cycles.

Reset
REQ-016 On Rst=0, asynchronously and independent of Clk, the block SHALL force:
- state = IDLE; counter, dm_streak = 0;
- mem_en, mem_we, if_done, dm_done = 0;
- mem_addr, mem_wdata, if_rdata, dm_rdata = 0.
REQ-017 A transaction in flight at reset SHALL be abandoned; no done pulse for it after reset release.
REQ-018 Arbitration SHALL resume on the first rising edge with Rst=1.

Verification (MEM_LAT=2, STARVE_MAX=4)
REQ-019 Single fetch: if_req=1, if_addr=0x00000010, memory returns 0x8C080004 at T+2 -> mem_en pulse at T; if_done at T+3 with if_rdata=0x8C080004; stall_if=1 for T..T+2.
REQ-020 Simultaneous: if_req and dm_req (load 0x100) rise together -> DM issued first; IF issued in dm_done cycle; if_done 3 cycles after dm_done.
REQ-021 Store: dm_we=1, dm_addr=0x200, dm_wdata=0xDEADBEEF -> mem_we=1 and mem_wdata=0xDEADBEEF with mem_en; dm_done at T+3; dm_rdata unchanged.
REQ-022 Starvation: dm_req held continuously with if_req=1 -> exactly 4 DM grants, then IF grant, then DM resumes.
REQ-023 Back-to-back same requester: dm_req held for two loads -> second mem_en one cycle after first dm_done, never in the done cycle.
REQ-024 Reset mid-transaction: Rst=0 at T+1 -> all outputs 0 immediately; no if_done/dm_done after release; fresh request issues normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Single-ported unified memory shared between instruction fetch and data access.
// One transaction in flight; data has priority, bounded by a starvation counter.
module mem_port_arbiter #(
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_rdata,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_done,
  output logic [31:0] dm_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        stall_if,
  output logic        stall_dm
);

  localparam logic [2:0] LAT  = 3'(MEM_LAT);
  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, WAIT_IF, WAIT_DM} state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [3:0]  streak_q, streak_d;
  logic [31:0] addr_q, wdata_q, if_rdata_q, dm_rdata_q;
  logic        we_q;

  logic        starve, arb_dm, arb_if;
  logic        grant_dm, grant_if, issue;
  logic        if_done_w, dm_done_w;

  assign if_done_w = (state_q == WAIT_IF) && (cnt_q == 3'd0);
  assign dm_done_w = (state_q == WAIT_DM) && (cnt_q == 3'd0);

  // Priority is evaluated normally; the requester that just completed is then
  // barred from issuing in its own done cycle, so it re-issues from IDLE.
  assign starve   = (streak_q == SMAX) && if_req;
  assign arb_dm   = dm_req && !starve;
  assign arb_if   = if_req && !arb_dm;
  assign grant_dm = arb_dm && ((state_q == IDLE) || if_done_w);
  assign grant_if = arb_if && ((state_q == IDLE) || dm_done_w);
  assign issue    = grant_dm || grant_if;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    streak_d = streak_q;
    case (state_q)
      WAIT_IF, WAIT_DM: begin
        if (cnt_q != 3'd0) cnt_d = cnt_q - 3'd1;
        else               state_d = IDLE;
      end
      default: ;
    endcase
    if (grant_dm) begin
      state_d = WAIT_DM;
      cnt_d   = LAT;
      if (!if_req)               streak_d = 4'd0;
      else if (streak_q != SMAX) streak_d = streak_q + 4'd1;
    end else if (grant_if) begin
      state_d  = WAIT_IF;
      cnt_d    = LAT;
      streak_d = 4'd0;
    end
  end

  // Command outputs are live in the issue cycle and replay the held copy otherwise.
  assign mem_en    = Rst && issue;
  assign mem_we    = mem_en ? (grant_dm && dm_we) : we_q;
  assign mem_addr  = mem_en ? (grant_dm ? dm_addr : if_addr) : addr_q;
  assign mem_wdata = mem_en ? (grant_dm ? dm_wdata : 32'd0) : wdata_q;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q    <= IDLE;
      cnt_q      <= 3'd0;
      streak_q   <= 4'd0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      we_q       <= 1'b0;
      if_rdata_q <= 32'd0;
      dm_rdata_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      streak_q <= streak_d;
      if (issue) begin
        addr_q  <= mem_addr;
        wdata_q <= mem_wdata;
        we_q    <= mem_we;
      end
      // Read data is valid on the last counted cycle, one before done.
      if (state_q == WAIT_IF && cnt_q == 3'd1)
        if_rdata_q <= mem_rdata;
      if (state_q == WAIT_DM && cnt_q == 3'd1 && !we_q)
        dm_rdata_q <= mem_rdata;
    end
  end

  assign if_done  = if_done_w;
  assign dm_done  = dm_done_w;
  assign if_rdata = if_rdata_q;
  assign dm_rdata = dm_rdata_q;
  assign stall_if = if_req & ~if_done_w;
  assign stall_dm = dm_req & ~dm_done_w;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (MEM_LAT=2, STARVE_MAX=4) with a small
// behavioural memory that returns read data two cycles after the command.
module tb_mem_port_arbiter;

  logic        Clk, Rst;
  logic        if_req, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata;
  logic        if_done, dm_done, mem_en, mem_we, stall_if, stall_dm;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  mem_port_arbiter #(.MEM_LAT(2), .STARVE_MAX(4)) dut (
    .Clk(Clk), .Rst(Rst),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_done(dm_done), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall_if(stall_if), .stall_dm(stall_dm)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Memory: unwritten words read as addr ^ 0x5A5A0000, except the fetch word at 0x10.
  logic [31:0] wm [0:1023];
  bit          wv [0:1023];
  logic [31:0] p1, p2;
  logic        v1, v2;

  function automatic logic [31:0] rd(input logic [31:0] a);
    if (wv[a[11:2]])        return wm[a[11:2]];
    if (a == 32'h0000_0010) return 32'h8C08_0004;
    return a ^ 32'h5A5A_0000;
  endfunction

  always @(posedge Clk) begin
    v1 <= mem_en & ~mem_we;
    p1 <= mem_addr;
    v2 <= v1;
    p2 <= p1;
    if (mem_en && mem_we) begin
      wm[mem_addr[11:2]] <= mem_wdata;
      wv[mem_addr[11:2]] <= 1'b1;
    end
  end

  assign mem_rdata = v2 ? rd(p2) : 32'hBAD0_BAD0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int          n, c, ndone;
  logic        gk [0:5];
  int          gc [0:5];
  int          exp_c [0:5];
  logic        exp_k [0:5];

  initial begin
    Rst = 1'b0; if_req = 0; dm_req = 0; dm_we = 0;
    if_addr = 0; dm_addr = 0; dm_wdata = 0;
    v1 = 0; v2 = 0; p1 = 0; p2 = 0;
    exp_c[0] = 0; exp_c[1] = 4; exp_c[2] = 8; exp_c[3] = 12; exp_c[4] = 15; exp_c[5] = 18;
    exp_k[0] = 0; exp_k[1] = 0; exp_k[2] = 0; exp_k[3] = 0; exp_k[4] = 1; exp_k[5] = 0;

    // reset state
    #3;
    chk("rst_mem_en", 32'(mem_en), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_dm_rdata", dm_rdata, 0);
    chk("rst_dones", {30'd0, if_done, dm_done}, 0);
    #9 Rst = 1'b1;
    step();

    // single fetch
    if_req = 1; if_addr = 32'h10; #1;
    chk("f_en", 32'(mem_en), 1);
    chk("f_addr", mem_addr, 32'h10);
    chk("f_we_wd", {31'd0, mem_we} | mem_wdata, 0);
    chk("f_stall_T", 32'(stall_if), 1);
    step();
    chk("f_en_T1", 32'(mem_en), 0);
    chk("f_addr_hold", mem_addr, 32'h10);
    chk("f_stall_T1", 32'(stall_if), 1);
    step();
    chk("f_stall_T2", 32'(stall_if), 1);
    chk("f_done_T2", 32'(if_done), 0);
    step();
    chk("f_done_T3", 32'(if_done), 1);
    chk("f_rdata", if_rdata, 32'h8C08_0004);
    chk("f_stall_T3", 32'(stall_if), 0);
    if_req = 0;
    step();
    chk("f_done_pulse", 32'(if_done), 0);

    // simultaneous request: DM first, IF issued in the dm_done cycle
    if_req = 1; if_addr = 32'h20; dm_req = 1; dm_we = 0; dm_addr = 32'h100; #1;
    chk("s_en", 32'(mem_en), 1);
    chk("s_dm_first", mem_addr, 32'h100);
    step(); step(); step();
    chk("s_dm_done", 32'(dm_done), 1);
    chk("s_dm_rdata", dm_rdata, 32'h5A5A_0100);
    dm_req = 0; #1;
    chk("s_if_in_done_en", 32'(mem_en), 1);
    chk("s_if_in_done_addr", mem_addr, 32'h20);
    step(); step(); step();
    chk("s_if_done", 32'(if_done), 1);
    chk("s_if_rdata", if_rdata, 32'h5A5A_0020);
    if_req = 0;
    step();

    // store
    dm_req = 1; dm_we = 1; dm_addr = 32'h200; dm_wdata = 32'hDEAD_BEEF; #1;
    chk("st_en", 32'(mem_en), 1);
    chk("st_we", 32'(mem_we), 1);
    chk("st_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("st_addr", mem_addr, 32'h200);
    step(); step(); step();
    chk("st_done", 32'(dm_done), 1);
    chk("st_stall_dm", 32'(stall_dm), 0);
    chk("st_rdata_kept", dm_rdata, 32'h5A5A_0100);
    dm_req = 0; dm_we = 0;
    step();

    // back-to-back loads from the same requester
    dm_req = 1; dm_addr = 32'h200; #1;
    chk("b2b_en1", 32'(mem_en), 1);
    step(); step(); step();
    chk("b2b_done1", 32'(dm_done), 1);
    chk("b2b_rdata1", dm_rdata, 32'hDEAD_BEEF);
    dm_addr = 32'h104; #1;
    chk("b2b_no_en_in_done", 32'(mem_en), 0);
    step();
    chk("b2b_en2", 32'(mem_en), 1);
    chk("b2b_addr2", mem_addr, 32'h104);
    step(); step(); step();
    chk("b2b_done2", 32'(dm_done), 1);
    chk("b2b_rdata2", dm_rdata, 32'h5A5A_0104);
    dm_req = 0;
    step();

    // starvation bound: four DM grants, then IF, then DM again
    dm_req = 1; dm_addr = 32'h300; if_req = 1; if_addr = 32'h40;
    n = 0; c = 0;
    while (n < 6 && c < 60) begin
      #1;
      if (mem_en) begin
        gk[n] = (mem_addr == 32'h40);
        gc[n] = c;
        if (gk[n]) chk("sv_if_we_wd", {31'd0, mem_we} | mem_wdata, 0);
        n++;
      end
      if (if_done) if_req = 0;
      step();
      c++;
    end
    chk("sv_grants", n, 6);
    for (int i = 0; i < 6; i++) begin
      if (i < n) begin
        chk($sformatf("sv_kind%0d", i), 32'(gk[i]), 32'(exp_k[i]));
        chk($sformatf("sv_cyc%0d", i), gc[i], exp_c[i]);
      end
    end
    step(); step();
    chk("sv_last_done", 32'(dm_done), 1);
    chk("sv_last_rdata", dm_rdata, 32'h5A5A_0300);
    dm_req = 0;
    step();

    // reset mid-transaction
    if_req = 1; if_addr = 32'h50; #1;
    chk("rm_en", 32'(mem_en), 1);
    step();
    Rst = 1'b0; #1;
    chk("rm_mem_en", 32'(mem_en), 0);
    chk("rm_mem_addr", mem_addr, 0);
    chk("rm_if_rdata", if_rdata, 0);
    chk("rm_dm_rdata", dm_rdata, 0);
    chk("rm_dones", {30'd0, if_done, dm_done}, 0);
    if_req = 0;
    @(posedge Clk);
    #2 Rst = 1'b1;
    ndone = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      ndone += int'(if_done) + int'(dm_done);
    end
    chk("rm_no_done", ndone, 0);
    dm_req = 1; dm_addr = 32'h200; #1;
    chk("rm_fresh_en", 32'(mem_en), 1);
    chk("rm_fresh_addr", mem_addr, 32'h200);
    step(); step(); step();
    chk("rm_fresh_done", 32'(dm_done), 1);
    chk("rm_fresh_rdata", dm_rdata, 32'hDEAD_BEEF);
    dm_req = 0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
